// File: rtl/voice_pkg.sv
// Shared types and default widths for the polyphonic voice allocator.
package voice_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_FREQ_W     = 32;
    localparam int DEF_KEY_W      = 7;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        ACTIVE  = 2'd1,
        RETRIG  = 2'd2,
        RELEASE = 2'd3
    } voice_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        COMMIT = 2'd2
    } ev_state_t;

    // Which rule picked the voice: A key match, B free, C oldest released,
    // D oldest sounding (a steal).
    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } sel_case_t;

endpackage

// File: rtl/voice_select.sv
// Combinational priority / oldest-voice search over the voice table.
// Note-on: key match on any busy voice, else lowest free, else oldest
// released, else oldest sounding. Note-off: lowest sounding key match only.
module voice_select
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int KEY_W      = DEF_KEY_W,
    parameter int AGE_W      = 8,
    parameter int IDX_W      = 2
)(
    input  voice_state_t     state [NUM_VOICES],
    input  logic [KEY_W-1:0] vkey  [NUM_VOICES],
    input  logic [AGE_W-1:0] age   [NUM_VOICES],
    input  logic [KEY_W-1:0] key,
    input  logic             on,
    output logic [IDX_W-1:0] idx,
    output sel_case_t        sel_case,
    output logic             found
);

    logic             a_hit, b_hit, c_hit, d_hit;
    logic [IDX_W-1:0] a_idx, b_idx, c_idx, d_idx;
    logic [AGE_W-1:0] c_age, d_age;
    logic             sounding;

    // Scan all voices for each rule, then resolve by rule priority
    always_comb begin
        a_hit = 1'b0; b_hit = 1'b0; c_hit = 1'b0; d_hit = 1'b0;
        a_idx = '0;   b_idx = '0;   c_idx = '0;   d_idx = '0;
        c_age = '0;   d_age = '0;
        sounding = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sounding = (state[i] == ACTIVE) || (state[i] == RETRIG);
            if (!a_hit && (vkey[i] == key) && (on ? (state[i] != FREE) : sounding)) begin
                a_hit = 1'b1;
                a_idx = IDX_W'(i);
            end
            if (!b_hit && (state[i] == FREE)) begin
                b_hit = 1'b1;
                b_idx = IDX_W'(i);
            end
            // strict compare keeps the lowest index on an age tie
            if ((state[i] == RELEASE) && (!c_hit || (age[i] > c_age))) begin
                c_hit = 1'b1;
                c_idx = IDX_W'(i);
                c_age = age[i];
            end
            if (sounding && (!d_hit || (age[i] > d_age))) begin
                d_hit = 1'b1;
                d_idx = IDX_W'(i);
                d_age = age[i];
            end
        end

        found    = 1'b0;
        idx      = '0;
        sel_case = SEL_A;
        if (a_hit) begin
            found = 1'b1; idx = a_idx; sel_case = SEL_A;
        end else if (on && b_hit) begin
            found = 1'b1; idx = b_idx; sel_case = SEL_B;
        end else if (on && c_hit) begin
            found = 1'b1; idx = c_idx; sel_case = SEL_C;
        end else if (on && d_hit) begin
            found = 1'b1; idx = d_idx; sel_case = SEL_D;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: takes note events over valid/ready, assigns
// them to voices (stealing the oldest if needed) and presents frequency and
// gate changes to the generator only on sample ticks.
//
// state  | meaning
// IDLE   | ev_ready high, waiting for an event
// SEARCH | voice_select result registered
// COMMIT | voice table updated from the registered selection
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int FREQ_W     = DEF_FREQ_W,
    parameter int KEY_W      = DEF_KEY_W,
    parameter int AGE_W      = 8,
    parameter int REL_TICKS  = 24000,
    parameter int REL_W      = 16
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_tick,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [KEY_W-1:0]             ev_key,
    input  logic [FREQ_W-1:0]            ev_freq,
    input  logic                         panic,
    output logic [NUM_VOICES*FREQ_W-1:0] freq_out,
    output logic [NUM_VOICES-1:0]        gate_out,
    output logic [NUM_VOICES-1:0]        voice_busy,
    output logic [15:0]                  steal_cnt
);

    localparam int               IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
    localparam logic [REL_W-1:0] REL_INIT = REL_W'(REL_TICKS);

    ev_state_t                   fsm_state, fsm_next;
    logic                        accept, commit;

    logic                        ev_on_q;
    logic [KEY_W-1:0]            ev_key_q;
    logic [FREQ_W-1:0]           ev_freq_q;

    logic [IDX_W-1:0]            sel_idx, sel_idx_q;
    sel_case_t                   sel_case, sel_case_q;
    logic                        sel_found, sel_found_q;

    voice_state_t                v_state  [NUM_VOICES];
    logic [KEY_W-1:0]            v_key    [NUM_VOICES];
    logic [FREQ_W-1:0]           v_shadow [NUM_VOICES];
    logic [AGE_W-1:0]            v_age    [NUM_VOICES];
    logic [REL_W-1:0]            v_rel    [NUM_VOICES];

    logic [NUM_VOICES*FREQ_W-1:0] freq_q;
    logic [NUM_VOICES-1:0]        gate_q;
    logic [15:0]                  steal_q;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .KEY_W      (KEY_W),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_select (
        .state    (v_state),
        .vkey     (v_key),
        .age      (v_age),
        .key      (ev_key_q),
        .on       (ev_on_q),
        .idx      (sel_idx),
        .sel_case (sel_case),
        .found    (sel_found)
    );

    // Event FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_state <= IDLE;
        else        fsm_state <= fsm_next;
    end

    // Event FSM next state and handshake; ready is gated by reset so it reads low while held
    always_comb begin
        fsm_next = fsm_state;
        ev_ready = 1'b0;
        accept   = 1'b0;
        case (fsm_state)
            IDLE: begin
                ev_ready = rst_n;
                if (ev_valid) begin
                    accept   = 1'b1;
                    fsm_next = SEARCH;
                end
            end
            SEARCH:  fsm_next = COMMIT;
            COMMIT:  fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    assign commit = (fsm_state == COMMIT) && sel_found_q;

    // Event capture, selection register, voice table and live outputs.
    // Within a voice the later assignment wins: commit over panic over tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_on_q     <= 1'b0;
            ev_key_q    <= '0;
            ev_freq_q   <= '0;
            sel_idx_q   <= '0;
            sel_case_q  <= SEL_A;
            sel_found_q <= 1'b0;
            steal_q     <= '0;
            freq_q      <= '0;
            gate_q      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                v_state[i]  <= FREE;
                v_key[i]    <= '0;
                v_shadow[i] <= '0;
                v_age[i]    <= '0;
                v_rel[i]    <= '0;
            end
        end else begin
            if (accept) begin
                ev_on_q   <= ev_on & ~panic;
                ev_key_q  <= ev_key;
                ev_freq_q <= ev_freq;
            end
            if (fsm_state == SEARCH) begin
                sel_idx_q   <= sel_idx;
                sel_case_q  <= sel_case;
                sel_found_q <= sel_found;
            end
            if (commit && ev_on_q && (sel_case_q == SEL_D))
                steal_q <= steal_q + 16'd1;

            for (int i = 0; i < NUM_VOICES; i++) begin
                if (sample_tick) begin
                    freq_q[i*FREQ_W +: FREQ_W] <= v_shadow[i];
                    gate_q[i] <= (v_state[i] == ACTIVE);
                    if ((v_state[i] != FREE) && (v_age[i] != AGE_MAX))
                        v_age[i] <= v_age[i] + AGE_W'(1);
                    if (v_state[i] == RETRIG)
                        v_state[i] <= ACTIVE;
                    if (v_state[i] == RELEASE) begin
                        if (v_rel[i] == '0) v_state[i] <= FREE;
                        else                v_rel[i]   <= v_rel[i] - REL_W'(1);
                    end
                end
                if (panic && ((v_state[i] == ACTIVE) || (v_state[i] == RETRIG))) begin
                    v_state[i] <= RELEASE;
                    v_rel[i]   <= REL_INIT;
                end
                if (commit && (sel_idx_q == IDX_W'(i))) begin
                    if (ev_on_q) begin
                        v_key[i]    <= ev_key_q;
                        v_shadow[i] <= ev_freq_q;
                        v_age[i]    <= '0;
                        v_rel[i]    <= '0;
                        v_state[i]  <= (sel_case_q == SEL_B) ? ACTIVE : RETRIG;
                    end else begin
                        v_state[i]  <= RELEASE;
                        v_rel[i]    <= REL_INIT;
                    end
                end
            end
        end
    end

    // Busy flags straight from the voice table
    always_comb begin
        voice_busy = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            voice_busy[i] = (v_state[i] != FREE);
    end

    assign freq_out  = freq_q;
    assign gate_out  = gate_q;
    assign steal_cnt = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: scripted vector table, hand
// sequences for tick/commit overlap, panic and mid-event reset, then
// randomized events and ticks against a behavioural voice model.
module tb_voice_allocator;

    localparam int REL_T = 6;
    localparam int OP_EV = 0;
    localparam int OP_TK = 1;
    localparam int M_FREE = 0, M_ON = 1, M_RETRIG = 2, M_REL = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_tick = 1'b0;
    logic         ev_valid = 1'b0;
    logic         ev_ready;
    logic         ev_on = 1'b0;
    logic [6:0]   ev_key = '0;
    logic [31:0]  ev_freq = '0;
    logic         panic = 1'b0;
    logic [127:0] freq_out;
    logic [3:0]   gate_out;
    logic [3:0]   voice_busy;
    logic [15:0]  steal_cnt;

    int checks = 0;
    int errors = 0;

    voice_allocator #(.REL_TICKS(REL_T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_key      (ev_key),
        .ev_freq     (ev_freq),
        .panic       (panic),
        .freq_out    (freq_out),
        .gate_out    (gate_out),
        .voice_busy  (voice_busy),
        .steal_cnt   (steal_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          op;
        int          n;
        logic        on;
        logic [6:0]  key;
        logic [31:0] freq;
        logic [3:0]  gate;
        logic [3:0]  busy;
        int          vsel;
        logic [31:0] vfreq;
        logic [15:0] steal;
    } vec_t;

    vec_t vecs[24];

    // behavioural model of the voice table
    int          m_state [4];
    int          m_key   [4];
    int          m_age   [4];
    int          m_rel   [4];
    logic [31:0] m_shadow[4];
    logic [31:0] m_live  [4];
    logic [3:0]  m_gate;
    int          m_steal;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ev_valid = 1'b0; sample_tick = 1'b0; panic = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk); sample_tick = 1'b1;
            @(negedge clk); sample_tick = 1'b0;
        end
    endtask

    task automatic send_event(input logic on, input logic [6:0] key, input logic [31:0] freq);
        int n;
        n = 0;
        @(negedge clk);
        while (!ev_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ev_ready) check("ready_wait", {127'd0, ev_ready}, 128'd1);
        ev_valid = 1'b1; ev_on = on; ev_key = key; ev_freq = freq;
        @(negedge clk);
        ev_valid = 1'b0;
        check("ready_search", {127'd0, ev_ready}, 128'd0);
        @(negedge clk);
        check("ready_commit", {127'd0, ev_ready}, 128'd0);
        @(negedge clk);
        check("ready_back", {127'd0, ev_ready}, 128'd1);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = M_FREE; m_key[i] = 0; m_age[i] = 0; m_rel[i] = 0;
            m_shadow[i] = '0; m_live[i] = '0;
        end
        m_gate = '0;
        m_steal = 0;
    endtask

    task automatic m_oldest(input bit rel, output int best);
        best = -1;
        for (int i = 0; i < 4; i++) begin
            if ((rel ? (m_state[i] == M_REL) : (m_state[i] == M_ON || m_state[i] == M_RETRIG)) &&
                (best < 0 || m_age[i] > m_age[best]))
                best = i;
        end
    endtask

    task automatic m_note_on(input int k, input logic [31:0] f);
        int v;
        bit fresh;
        v = -1; fresh = 1'b0;
        for (int i = 0; i < 4; i++)
            if (v < 0 && m_state[i] != M_FREE && m_key[i] == k) v = i;
        if (v < 0)
            for (int i = 0; i < 4; i++)
                if (v < 0 && m_state[i] == M_FREE) begin v = i; fresh = 1'b1; end
        if (v < 0) m_oldest(1'b1, v);
        if (v < 0) begin
            m_oldest(1'b0, v);
            m_steal++;
        end
        m_key[v] = k; m_shadow[v] = f; m_age[v] = 0;
        m_state[v] = fresh ? M_ON : M_RETRIG;
    endtask

    task automatic m_note_off(input int k);
        for (int i = 0; i < 4; i++)
            if ((m_state[i] == M_ON || m_state[i] == M_RETRIG) && m_key[i] == k) begin
                m_state[i] = M_REL; m_rel[i] = REL_T;
                return;
            end
    endtask

    task automatic m_panic();
        for (int i = 0; i < 4; i++)
            if (m_state[i] == M_ON || m_state[i] == M_RETRIG) begin
                m_state[i] = M_REL; m_rel[i] = REL_T;
            end
    endtask

    task automatic m_tick();
        for (int i = 0; i < 4; i++) begin
            m_live[i] = m_shadow[i];
            m_gate[i] = (m_state[i] == M_ON);
            if (m_state[i] != M_FREE && m_age[i] < 255) m_age[i]++;
            if (m_state[i] == M_RETRIG) m_state[i] = M_ON;
            else if (m_state[i] == M_REL) begin
                if (m_rel[i] == 0) m_state[i] = M_FREE;
                else m_rel[i]--;
            end
        end
    endtask

    task automatic m_compare(input int step);
        logic [127:0] ef;
        logic [3:0]   eb;
        for (int i = 0; i < 4; i++) begin
            ef[i*32 +: 32] = m_live[i];
            eb[i] = (m_state[i] != M_FREE);
        end
        check($sformatf("rand_gate[%0d]", step), {124'd0, gate_out}, {124'd0, m_gate});
        check($sformatf("rand_busy[%0d]", step), {124'd0, voice_busy}, {124'd0, eb});
        check($sformatf("rand_freq[%0d]", step), freq_out, ef);
        check($sformatf("rand_steal[%0d]", step), {112'd0, steal_cnt}, {112'd0, m_steal[15:0]});
    endtask

    initial begin
        vecs[0]  = '{OP_EV, 0,  1'b1, 7'd60, 32'h555, 4'b0000, 4'b0001, 0, 32'h000, 16'd0};
        vecs[1]  = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b0001, 4'b0001, 0, 32'h555, 16'd0};
        vecs[2]  = '{OP_EV, 0,  1'b1, 7'd61, 32'h611, 4'b0001, 4'b0011, 1, 32'h000, 16'd0};
        vecs[3]  = '{OP_EV, 0,  1'b1, 7'd62, 32'h622, 4'b0001, 4'b0111, 2, 32'h000, 16'd0};
        vecs[4]  = '{OP_EV, 0,  1'b1, 7'd63, 32'h633, 4'b0001, 4'b1111, 3, 32'h000, 16'd0};
        vecs[5]  = '{OP_TK, 10, 1'b0, 7'd0,  32'h000, 4'b1111, 4'b1111, 3, 32'h633, 16'd0};
        vecs[6]  = '{OP_EV, 0,  1'b1, 7'd64, 32'h644, 4'b1111, 4'b1111, 0, 32'h555, 16'd1};
        vecs[7]  = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1110, 4'b1111, 0, 32'h644, 16'd1};
        vecs[8]  = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1111, 4'b1111, 0, 32'h644, 16'd1};
        vecs[9]  = '{OP_EV, 0,  1'b0, 7'd61, 32'h000, 4'b1111, 4'b1111, 1, 32'h611, 16'd1};
        vecs[10] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1101, 4'b1111, 1, 32'h611, 16'd1};
        vecs[11] = '{OP_TK, 5,  1'b0, 7'd0,  32'h000, 4'b1101, 4'b1111, 1, 32'h611, 16'd1};
        vecs[12] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1101, 4'b1101, 1, 32'h611, 16'd1};
        vecs[13] = '{OP_EV, 0,  1'b0, 7'd61, 32'h000, 4'b1101, 4'b1101, 1, 32'h611, 16'd1};
        vecs[14] = '{OP_EV, 0,  1'b1, 7'd65, 32'h655, 4'b1101, 4'b1111, 1, 32'h611, 16'd1};
        vecs[15] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1111, 4'b1111, 1, 32'h655, 16'd1};
        vecs[16] = '{OP_EV, 0,  1'b0, 7'd62, 32'h000, 4'b1111, 4'b1111, 2, 32'h622, 16'd1};
        vecs[17] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1011, 4'b1111, 2, 32'h622, 16'd1};
        vecs[18] = '{OP_EV, 0,  1'b1, 7'd70, 32'h700, 4'b1011, 4'b1111, 2, 32'h622, 16'd1};
        vecs[19] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1011, 4'b1111, 2, 32'h700, 16'd1};
        vecs[20] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1111, 4'b1111, 2, 32'h700, 16'd1};
        vecs[21] = '{OP_EV, 0,  1'b1, 7'd70, 32'h710, 4'b1111, 4'b1111, 2, 32'h700, 16'd1};
        vecs[22] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1011, 4'b1111, 2, 32'h710, 16'd1};
        vecs[23] = '{OP_TK, 1,  1'b0, 7'd0,  32'h000, 4'b1111, 4'b1111, 2, 32'h710, 16'd1};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {127'd0, ev_ready}, 128'd0);
        check("rst_gate",  {124'd0, gate_out}, 128'd0);
        check("rst_busy",  {124'd0, voice_busy}, 128'd0);
        check("rst_freq",  freq_out, 128'd0);
        check("rst_steal", {112'd0, steal_cnt}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {127'd0, ev_ready}, 128'd1);

        // scripted table
        for (int v = 0; v < 24; v++) begin
            if (vecs[v].op == OP_EV) send_event(vecs[v].on, vecs[v].key, vecs[v].freq);
            else                     tick_n(vecs[v].n);
            check($sformatf("vec%0d_gate", v), {124'd0, gate_out}, {124'd0, vecs[v].gate});
            check($sformatf("vec%0d_busy", v), {124'd0, voice_busy}, {124'd0, vecs[v].busy});
            check($sformatf("vec%0d_freq", v), {96'd0, freq_out[vecs[v].vsel*32 +: 32]}, {96'd0, vecs[v].vfreq});
            check($sformatf("vec%0d_steal", v), {112'd0, steal_cnt}, {112'd0, vecs[v].steal});
        end

        // commit coincident with a sample tick
        do_reset();
        send_event(1'b1, 7'd60, 32'h555);
        tick_n(1);
        @(negedge clk); ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd60; ev_freq = 32'h999;
        @(negedge clk); ev_valid = 1'b0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        check("coinc_gate_same", {124'd0, gate_out}, 128'h1);
        check("coinc_freq_same", {96'd0, freq_out[31:0]}, 128'h555);
        tick_n(1);
        check("coinc_gate_low", {124'd0, gate_out}, 128'h0);
        check("coinc_freq_new", {96'd0, freq_out[31:0]}, 128'h999);
        tick_n(1);
        check("coinc_gate_back", {124'd0, gate_out}, 128'h1);

        // panic with three voices sounding, then a note-on under panic
        do_reset();
        send_event(1'b1, 7'd40, 32'h100);
        send_event(1'b1, 7'd41, 32'h200);
        send_event(1'b1, 7'd42, 32'h300);
        tick_n(1);
        check("pre_panic_gate", {124'd0, gate_out}, 128'h7);
        @(negedge clk); panic = 1'b1;
        repeat (3) @(negedge clk);
        panic = 1'b0;
        tick_n(1);
        check("panic_gate", {124'd0, gate_out}, 128'h0);
        check("panic_busy", {124'd0, voice_busy}, 128'h7);
        panic = 1'b1;
        send_event(1'b1, 7'd80, 32'h800);
        panic = 1'b0;
        check("panic_forced_off", {124'd0, voice_busy}, 128'h7);

        // reset asserted while SEARCH is in flight
        do_reset();
        for (int i = 0; i < 5; i++) send_event(1'b1, 7'(50 + i), 32'(32'h1000 + i));
        tick_n(1);
        check("pre_rst_steal", {112'd0, steal_cnt}, 128'd1);
        @(negedge clk); ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd90; ev_freq = 32'hABC;
        @(negedge clk); ev_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("midrst_gate",  {124'd0, gate_out}, 128'd0);
        check("midrst_busy",  {124'd0, voice_busy}, 128'd0);
        check("midrst_freq",  freq_out, 128'd0);
        check("midrst_steal", {112'd0, steal_cnt}, 128'd0);
        check("midrst_ready", {127'd0, ev_ready}, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", {127'd0, ev_ready}, 128'd1);

        // randomized events and ticks against the model
        do_reset();
        m_reset();
        for (int s = 0; s < 400; s++) begin
            int          op;
            bit          pn;
            bit          on;
            int          k;
            logic [31:0] f;
            op = int'($urandom_range(0, 2));
            pn = ($urandom_range(0, 9) == 0);
            on = ($urandom_range(0, 9) < 7);
            k  = 60 + int'($urandom_range(0, 5));
            f  = $urandom;
            if (pn) begin
                @(negedge clk); panic = 1'b1;
                m_panic();
            end
            if (op == 0) begin
                tick_n(1);
                m_tick();
            end else begin
                send_event(on, 7'(k), f);
                if (on && !pn) m_note_on(k, f);
                else           m_note_off(k);
            end
            panic = 1'b0;
            m_compare(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the RocketCPU note-event register path and the 4-voice multigenerator and gate/envelope inputs.
- Accepts note-on/note-off events over a valid/ready handshake, assigns them to free voices, and steals the oldest voice when none are free.
- Stages all frequency and gate changes and applies them only on sample ticks, so the generator and envelopes never see a mid-sample glitch.

Parameters:
- NUM_VOICES, 4: voices managed; fixed at 4 for the current generator.
- FREQ_W, 32: phase-increment width; matches the generator freq inputs.
- KEY_W, 7: note key id width (MIDI key number).
- AGE_W, 8: per-voice age counter width; saturates.
- REL_TICKS, 24000: sample ticks a released voice stays in RELEASE before FREE (0.5 s at 48 kHz).
- REL_W, 16: release counter width; REL_TICKS must be < 2^REL_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sample_tick  in  1  one-clk pulse per audio sample, already synchronised to clk.
- ev_valid  in  1  event present.
- ev_ready  out  1  controller can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_key  in  KEY_W  note key.
- ev_freq  in  FREQ_W  phase increment for note-on; ignored for note-off.
- panic  in  1  level; forces all non-FREE voices to RELEASE.
- freq_out  out  NUM_VOICES*FREQ_W  live phase increments; voice 0 in the LSBs.
- gate_out  out  NUM_VOICES  live gates to the envelope generators.
- voice_busy  out  NUM_VOICES  1 when the voice state is not FREE.
- steal_cnt  out  16  count of stolen voices; wraps.

Behaviour:
- Reset values: ev_ready=0 during reset and 1 in the first cycle after release. All voices FREE. freq_out=0, gate_out=0, voice_busy=0, steal_cnt=0. Ages and release counters =0.
- Per-voice state: FREE, ACTIVE, RETRIG, RELEASE. Each voice also holds a key, a shadow frequency, an age counter and a release counter.
- Event FSM:
  - IDLE: ev_ready=1. An event is accepted when ev_valid & ev_ready; the fields are latched and the FSM moves to SEARCH.
  - SEARCH (1 cycle): registers the match and selection results.
  - COMMIT (1 cycle): updates the voice table.
  - The FSM returns to IDLE after COMMIT. ev_ready=0 in SEARCH and COMMIT, so at most one event is accepted every 3 cycles.
- Note-on selection, in priority order:
  - (a) a non-FREE voice with an equal key: retrigger that voice.
  - (b) the lowest-index FREE voice.
  - (c) the RELEASE voice with the maximum age.
  - (d) the ACTIVE or RETRIG voice with the maximum age; steal_cnt increments.
  - Age ties go to the lowest index.
- Note-on commit:
  - The voice loads the key, its shadow freq gets ev_freq, and age=0.
  - (b) sets the voice to ACTIVE.
  - (a), (c) and (d) set it to RETRIG, so the envelope restarts.
- Note-off:
  - The lowest-index ACTIVE or RETRIG voice with an equal key goes to RELEASE, with release counter=REL_TICKS.
  - With no match the event is consumed and nothing changes.
- On each sample_tick:
  - Live freq is loaded from shadow freq.
  - Live gate = 1 for ACTIVE; 0 for RETRIG, RELEASE and FREE.
  - After sampling, RETRIG goes to ACTIVE, so the gate is low for exactly one sample.
  - Ages increment, saturating at 2^AGE_W-1, for non-FREE voices.
  - RELEASE voices decrement their release counter; a voice whose counter is 0 at the tick goes to FREE.
- Tick in the same cycle as COMMIT:
  - Live outputs sample the pre-commit state; the commit appears at the next tick.
  - For the committed voice, commit values win over the tick's age and release updates.
  - Other voices take the tick updates normally.
- panic:
  - While high, every ACTIVE or RETRIG voice goes to RELEASE with counter=REL_TICKS.
  - Events are still accepted but are forced to note-off semantics.
  - Voices already in RELEASE continue counting down.
- A FREE voice keeps its last live freq; its gate is 0.
- Reset asserted mid-event aborts the event; all state returns to reset values asynchronously.

Decomposition:
- Shared package voice_pkg holds:
  - voice state enum {FREE, ACTIVE, RETRIG, RELEASE};
  - event FSM enum {IDLE, SEARCH, COMMIT};
  - default widths FREQ_W=32, KEY_W=7.
- One sub-module, voice_select: combinational priority/oldest search over the voice table. Outputs: selected index, case (a/b/c/d), match-found flag. It is shared by the note-on and note-off paths.

Test Plan:
1. After reset, note-on key 60 freq 0x0555: accepted with ev_ready low for 2 cycles. Voice 0 is ACTIVE. At the next tick gate_out=0001 and freq_out[31:0]=0x0555.
2. Four note-ons (keys 60–63), wait 10 ticks, then note-on key 64: voice 0 (oldest) is stolen and steal_cnt=1. gate_out[0]=0 for exactly one tick, then 1 with the new freq.
3. Note-off key 61, then count ticks: voice 1 gate drops at the next tick and voice_busy[1] clears after REL_TICKS+1 ticks. A second note-off for key 61 changes nothing.
4. Voices 0–3 all ACTIVE and voice 2 released, then note-on key 70: voice 2 is reused via case (c) with no steal_cnt increment.
5. COMMIT coincident with sample_tick: live outputs are unchanged that tick and the new freq appears on the following tick. Also: note-on key 60 while key 60 is held retriggers the same voice (one-tick gate low).
6. panic held for 3 cycles with 3 voices active: all gates are 0 at the next tick. Asserting rst_n=0 during SEARCH clears all outputs immediately.
